id_issue_stage: RTL and testbench

- Parametrised decode/issue stage between fetch and execute.
- Accepts one instruction per cycle over a valid/ready handshake and resolves operands through an N-source forwarding mux.
- Detects load-use hazards internally and inserts a single-cycle interlock; no external hazard unit is involved for this case.
- Issues a registered, decoded bundle to EX through a 2-entry skid buffer, so EX back-pressure never forms a combinational path back to fetch.

---
 rtl/id_pkg.sv | 45 ++++
 rtl/id_skid_buf.sv | 59 +++++
 rtl/id_issue_stage.sv | 152 +++++++++++++++
 tb/tb_id_issue_stage.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode constants and the issue bundle layout for the ID/issue stage.
package id_pkg;

    localparam int unsigned ID_XLEN    = 32;
    localparam int unsigned ID_NREGS   = 32;
    localparam int unsigned ID_RW      = $clog2(ID_NREGS);
    localparam int unsigned ID_CTRL_W  = 16;
    localparam int unsigned ID_INSTR_W = 32;
    localparam int unsigned ID_OPC_W   = 6;

    // Bit positions inside the pre-decoded control word
    localparam int unsigned CTRL_MEMREAD  = 0;
    localparam int unsigned CTRL_REGWRITE = 1;
    localparam int unsigned CTRL_REGDST   = 2;

    // Instruction field slices
    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 26;
    localparam int unsigned RS_HI  = 25;
    localparam int unsigned RS_LO  = 21;
    localparam int unsigned RT_HI  = 20;
    localparam int unsigned RT_LO  = 16;
    localparam int unsigned RD_HI  = 15;
    localparam int unsigned RD_LO  = 11;
    localparam int unsigned IMM_HI = 15;
    localparam int unsigned IMM_LO = 0;

    typedef struct packed {
        logic [ID_CTRL_W-1:0] ctrl;
        logic [ID_OPC_W-1:0]  opcode;
        logic [ID_RW-1:0]     reg_s;
        logic [ID_RW-1:0]     reg_t;
        logic [ID_RW-1:0]     reg_d;
        logic [ID_XLEN-1:0]   data_s;
        logic [ID_XLEN-1:0]   data_t;
        logic [ID_XLEN-1:0]   imm;
        logic [ID_XLEN-1:0]   pc_next;
        logic [ID_XLEN-1:0]   pc_jump;
    } id_bundle_t;

    function automatic logic [ID_XLEN-1:0] sext16(input logic [15:0] v);
        return {{(ID_XLEN - 16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_skid_buf.sv
// Two-entry valid/ready buffer; entry 0 drives the output, in_ready depends only on state.
module id_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] e0_q;
    logic [W-1:0] e1_q;
    logic         v0_q;
    logic         v1_q;
    logic         push;
    logic         pop;

    assign in_ready  = !v1_q;
    assign push      = in_valid && !v1_q && !flush;
    assign pop       = v0_q && out_ready;
    assign out_valid = v0_q;
    assign out_data  = e0_q;

    // Flush has priority over any simultaneous push or pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e0_q <= '0;
            e1_q <= '0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else if (flush) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else if (v1_q) begin
            if (pop) begin
                e0_q <= e1_q;
                v1_q <= 1'b0;
            end
        end else if (v0_q) begin
            if (push && pop) begin
                e0_q <= in_data;
            end else if (push) begin
                e1_q <= in_data;
                v1_q <= 1'b1;
            end else if (pop) begin
                v0_q <= 1'b0;
            end
        end else if (push) begin
            e0_q <= in_data;
            v0_q <= 1'b1;
        end
    end

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: operand forwarding, load-use interlock, skid-buffered issue to EX.
// Optional perf counters enabled by defining ID_ISSUE_PERF_EN.
module id_issue_stage
    import id_pkg::*;
#(
    parameter int unsigned XLEN    = ID_XLEN,
    parameter int unsigned NREGS   = ID_NREGS,
    parameter int unsigned NFWD    = 3,
    parameter int unsigned CTRL_W  = ID_CTRL_W,
    localparam int unsigned RW     = $clog2(NREGS),
    localparam int unsigned SW     = $clog2(NFWD + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ID_INSTR_W-1:0]  instruction,
    input  logic [XLEN-1:0]        pc_next,
    input  logic [CTRL_W-1:0]      ctrl_in,
    output logic [RW-1:0]          rf_raddr_s,
    output logic [RW-1:0]          rf_raddr_t,
    input  logic [XLEN-1:0]        rf_rdata_s,
    input  logic [XLEN-1:0]        rf_rdata_t,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    input  logic [SW-1:0]          fwd_sel_s,
    input  logic [SW-1:0]          fwd_sel_t,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [ID_OPC_W-1:0]    out_opcode,
    output logic [RW-1:0]          out_reg_s,
    output logic [RW-1:0]          out_reg_t,
    output logic [RW-1:0]          out_reg_d,
    output logic [XLEN-1:0]        out_data_s,
    output logic [XLEN-1:0]        out_data_t,
    output logic [XLEN-1:0]        out_imm,
    output logic [XLEN-1:0]        out_pc_next,
    output logic [XLEN-1:0]        out_pc_jump
`ifdef ID_ISSUE_PERF_EN
    ,
    output logic [31:0]            stall_cnt,
    output logic [31:0]            bubble_cnt
`endif
);

    logic [RW-1:0]   rs;
    logic [RW-1:0]   rt;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data_s_c;
    logic [XLEN-1:0] data_t_c;
    logic            init_q;
    logic            trk_memread_q;
    logic [RW-1:0]   trk_dst_q;
    logic            hazard;
    logic            accept;
    logic            skid_ready;
    id_bundle_t      in_b;
    id_bundle_t      out_b;

    assign rs         = RW'(instruction[RS_HI:RS_LO]);
    assign rt         = RW'(instruction[RT_HI:RT_LO]);
    assign rd         = RW'(instruction[RD_HI:RD_LO]);
    assign rf_raddr_s = rs;
    assign rf_raddr_t = rt;

    // Select 0 and any out-of-range select fall back to register file data
    always_comb begin
        data_s_c = rf_rdata_s;
        data_t_c = rf_rdata_t;
        for (int unsigned k = 0; k < NFWD; k++) begin
            if (fwd_sel_s == SW'(k + 1)) data_s_c = fwd_data[k*XLEN +: XLEN];
            if (fwd_sel_t == SW'(k + 1)) data_t_c = fwd_data[k*XLEN +: XLEN];
        end
    end

    assign hazard   = trk_memread_q && (trk_dst_q != '0) && in_valid
                      && ((rs == trk_dst_q) || (rt == trk_dst_q));
    assign in_ready = init_q && skid_ready && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    // Tracker only ever describes the instruction accepted on the previous cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_q        <= 1'b0;
            trk_memread_q <= 1'b0;
            trk_dst_q     <= '0;
        end else begin
            init_q <= 1'b1;
            if (accept) begin
                trk_memread_q <= ctrl_in[CTRL_MEMREAD];
                trk_dst_q     <= ctrl_in[CTRL_REGDST] ? rd : rt;
            end else begin
                trk_memread_q <= 1'b0;
                trk_dst_q     <= '0;
            end
        end
    end

    always_comb begin
        in_b         = '0;
        in_b.ctrl    = ID_CTRL_W'(ctrl_in);
        in_b.opcode  = instruction[OPC_HI:OPC_LO];
        in_b.reg_s   = ID_RW'(rs);
        in_b.reg_t   = ID_RW'(rt);
        in_b.reg_d   = ID_RW'(rd);
        in_b.data_s  = ID_XLEN'(data_s_c);
        in_b.data_t  = ID_XLEN'(data_t_c);
        in_b.imm     = sext16(instruction[IMM_HI:IMM_LO]);
        in_b.pc_next = ID_XLEN'(pc_next);
        in_b.pc_jump = ID_XLEN'({pc_next[XLEN-1:28], instruction[25:0], 2'b00});
    end

    id_skid_buf #(
        .W($bits(id_bundle_t))
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (accept),
        .in_ready  (skid_ready),
        .in_data   (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_b)
    );

    assign out_ctrl    = CTRL_W'(out_b.ctrl);
    assign out_opcode  = out_b.opcode;
    assign out_reg_s   = RW'(out_b.reg_s);
    assign out_reg_t   = RW'(out_b.reg_t);
    assign out_reg_d   = RW'(out_b.reg_d);
    assign out_data_s  = XLEN'(out_b.data_s);
    assign out_data_t  = XLEN'(out_b.data_t);
    assign out_imm     = XLEN'(out_b.imm);
    assign out_pc_next = XLEN'(out_b.pc_next);
    assign out_pc_jump = XLEN'(out_b.pc_jump);

`ifdef ID_ISSUE_PERF_EN
    // Saturating counters; only reset clears them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if (out_ready && !out_valid && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_issue_stage.sv
// Self-checking bench for id_issue_stage: queue-based reference model plus directed literal checks.
module tb_id_issue_stage;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NFWD = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  instruction = '0;
    logic [31:0]  pc_next = '0;
    logic [15:0]  ctrl_in = '0;
    logic [4:0]   rf_raddr_s, rf_raddr_t;
    logic [31:0]  rf_rdata_s, rf_rdata_t;
    logic [95:0]  fwd_data = '0;
    logic [1:0]   fwd_sel_s = '0;
    logic [1:0]   fwd_sel_t = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [15:0]  out_ctrl;
    logic [5:0]   out_opcode;
    logic [4:0]   out_reg_s, out_reg_t, out_reg_d;
    logic [31:0]  out_data_s, out_data_t, out_imm, out_pc_next, out_pc_jump;
`ifdef ID_ISSUE_PERF_EN
    logic [31:0]  stall_cnt, bubble_cnt;
`endif

    id_issue_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_next(pc_next), .ctrl_in(ctrl_in),
        .rf_raddr_s(rf_raddr_s), .rf_raddr_t(rf_raddr_t),
        .rf_rdata_s(rf_rdata_s), .rf_rdata_t(rf_rdata_t),
        .fwd_data(fwd_data), .fwd_sel_s(fwd_sel_s), .fwd_sel_t(fwd_sel_t),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_opcode(out_opcode),
        .out_reg_s(out_reg_s), .out_reg_t(out_reg_t), .out_reg_d(out_reg_d),
        .out_data_s(out_data_s), .out_data_t(out_data_t), .out_imm(out_imm),
        .out_pc_next(out_pc_next), .out_pc_jump(out_pc_jump)
`ifdef ID_ISSUE_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Register file stand-in: value is a tag plus the register number
    assign rf_rdata_s = 32'hA000_0000 + 32'(rf_raddr_s);
    assign rf_rdata_t = 32'hB000_0000 + 32'(rf_raddr_t);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        logic [31:0] ctrl, opcode, rs, rt, rd, ds, dt, imm, pcn, pcj;
    } bund_t;

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                         input logic [95:0] fwd);
        if (sel == 2'd0 || int'(sel) > NFWD) return rf;
        return 32'(fwd >> (32 * (int'(sel) - 1)));
    endfunction

    function automatic bund_t expect_of(input logic [31:0] ins, input logic [15:0] ctl,
                                        input logic [31:0] pcn, input logic [1:0] ss,
                                        input logic [1:0] st, input logic [95:0] fwd);
        bund_t b;
        b.ctrl   = 32'(ctl);
        b.opcode = 32'(ins[31:26]);
        b.rs     = 32'(ins[25:21]);
        b.rt     = 32'(ins[20:16]);
        b.rd     = 32'(ins[15:11]);
        b.ds     = pick(ss, 32'hA000_0000 + b.rs, fwd);
        b.dt     = pick(st, 32'hB000_0000 + b.rt, fwd);
        b.imm    = ins[15] ? (32'hFFFF_0000 | 32'(ins[15:0])) : 32'(ins[15:0]);
        b.pcn    = pcn;
        b.pcj    = (pcn & 32'hF000_0000) | (32'(ins[25:0]) << 2);
        return b;
    endfunction

    // Reference model: FIFO of issued bundles, plus the load accepted on the previous cycle
    bund_t       q[$];
    logic        m_started = 1'b0;
    logic        m_ld_armed = 1'b0;
    logic [31:0] m_ld_dst = '0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_bubble = '0;

    always @(negedge clk) begin
        logic        haz, rdy_e, val_e, acc;
        logic [31:0] rs, rt;
        if (!reset) begin
            q.delete();
            m_started  = 1'b0;
            m_ld_armed = 1'b0;
            m_stall    = '0;
            m_bubble   = '0;
        end else begin
            rs    = 32'(instruction[25:21]);
            rt    = 32'(instruction[20:16]);
            haz   = m_ld_armed && m_ld_dst != 0 && in_valid && (rs == m_ld_dst || rt == m_ld_dst);
            rdy_e = m_started && q.size() < 2 && !haz && !flush;
            val_e = q.size() > 0;
            chk("in_ready", 32'(in_ready), 32'(rdy_e));
            chk("out_valid", 32'(out_valid), 32'(val_e));
            chk("rf_raddr_s", 32'(rf_raddr_s), rs);
            chk("rf_raddr_t", 32'(rf_raddr_t), rt);
`ifdef ID_ISSUE_PERF_EN
            chk("stall_cnt", stall_cnt, m_stall);
            chk("bubble_cnt", bubble_cnt, m_bubble);
            if (in_valid && !rdy_e) m_stall++;
            if (out_ready && !val_e) m_bubble++;
`endif
            if (val_e) begin
                chk("out_ctrl", 32'(out_ctrl), q[0].ctrl);
                chk("out_opcode", 32'(out_opcode), q[0].opcode);
                chk("out_reg_s", 32'(out_reg_s), q[0].rs);
                chk("out_reg_t", 32'(out_reg_t), q[0].rt);
                chk("out_reg_d", 32'(out_reg_d), q[0].rd);
                chk("out_data_s", out_data_s, q[0].ds);
                chk("out_data_t", out_data_t, q[0].dt);
                chk("out_imm", out_imm, q[0].imm);
                chk("out_pc_next", out_pc_next, q[0].pcn);
                chk("out_pc_jump", out_pc_jump, q[0].pcj);
            end
            acc = in_valid && rdy_e;
            if (flush) begin
                q.delete();
                m_ld_armed = 1'b0;
            end else begin
                if (val_e && out_ready) void'(q.pop_front());
                if (acc) q.push_back(expect_of(instruction, ctrl_in, pc_next,
                                               fwd_sel_s, fwd_sel_t, fwd_data));
                m_ld_armed = acc && ctrl_in[0];
                m_ld_dst   = ctrl_in[2] ? 32'(instruction[15:11]) : rt;
            end
            m_started = 1'b1;
        end
    end

    logic [31:0] pcn_ctr = 32'hF000_0100;

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one instruction and hold it until accepted; returns the stall cycle count
    task automatic send(input logic [31:0] ins, input logic [15:0] ctl, output int stalls);
        instruction = ins;
        ctrl_in     = ctl;
        pc_next     = pcn_ctr;
        pcn_ctr     = pcn_ctr + 32'd4;
        in_valid    = 1'b1;
        stalls      = 0;
        @(negedge clk);
        while (!in_ready && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready still 0 after %0d cycles, expected 1", stalls);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    localparam logic [15:0] C_ALU  = 16'h0002;
    localparam logic [15:0] C_LOAD = 16'h0003;
    localparam logic [15:0] C_RTYP = 16'h0006;

    initial begin
        int s;
        logic [31:0] pc_a;
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic [31:0] pc_a;

        // Reset state
        step(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data_s", out_data_s, 32'd0);
        chk("rst_out_pc_jump", out_pc_jump, 32'd0);
        reset = 1'b1;
        chk("pre_edge_in_ready", 32'(in_ready), 32'd0);
        step(1);
        chk("post_edge_in_ready", 32'(in_ready), 32'd1);

        // Streaming addi r1..r5
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            send(i_type(6'h08, 5'd0, 5'(k), (k % 2 == 1) ? 16'h0010 : 16'hFFF0), C_ALU, s);
            chk("stream_stall", 32'(s), 32'd0);
            if (k == 1) chk("imm_pos", out_imm, 32'h0000_0010);
            if (k == 2) chk("imm_neg", out_imm, 32'hFFFF_FFF0);
        end
        step(2);

        // Back-pressure: two accepts fill the buffer, head holds
        out_ready = 1'b0;
        pc_a = pcn_ctr;
        send(i_type(6'h08, 5'd1, 5'd6, 16'h0100), C_ALU, s);
        send(i_type(6'h08, 5'd2, 5'd7, 16'h8000), C_ALU, s);
        instruction = i_type(6'h08, 5'd3, 5'd8, 16'h0001);
        pc_next = pcn_ctr;
        in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_head_pc", out_pc_next, pc_a);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(i_type(6'h08, 5'd3, 5'd8, 16'h0001), C_ALU, s);
        step(4);

        // Load-use interlock, then the same sequence targeting r0
        send(i_type(6'h23, 5'd1, 5'd3, 16'h0004), C_LOAD, s);
        send(r_type(5'd3, 5'd2, 5'd4), C_RTYP, s);
        chk("loaduse_stall", 32'(s), 32'd1);
        send(i_type(6'h23, 5'd1, 5'd0, 16'h0004), C_LOAD, s);
        send(r_type(5'd0, 5'd2, 5'd4), C_RTYP, s);
        chk("r0_no_stall", 32'(s), 32'd0);
        send(i_type(6'h23, 5'd1, 5'd9, 16'h0008), C_LOAD, s);
        send(r_type(5'd2, 5'd9, 5'd4), C_RTYP, s);
        chk("loaduse_rt_stall", 32'(s), 32'd1);
        step(2);

        // Forwarding mux
        fwd_data  = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111};
        fwd_sel_s = 2'd2;
        fwd_sel_t = 2'd0;
        send(i_type(6'h08, 5'd6, 5'd7, 16'h0002), C_ALU, s);
        chk("fwd_data_s", out_data_s, 32'hDEAD_BEEF);
        chk("fwd_data_t_rf", out_data_t, 32'hB000_0007);
        fwd_sel_s = 2'd3;
        fwd_sel_t = 2'd1;
        send(i_type(6'h08, 5'd6, 5'd7, 16'h0003), C_ALU, s);
        chk("fwd_sel3", out_data_s, 32'h3333_3333);
        chk("fwd_sel1", out_data_t, 32'h1111_1111);
        fwd_sel_s = 2'd0;
        fwd_sel_t = 2'd0;
        step(2);

        // Flush with both entries held and a dependent instruction waiting
        out_ready = 1'b0;
        send(i_type(6'h08, 5'd1, 5'd5, 16'h0005), C_ALU, s);
        send(i_type(6'h23, 5'd1, 5'd3, 16'h0004), C_LOAD, s);
        instruction = r_type(5'd3, 5'd2, 5'd4);
        ctrl_in = C_RTYP;
        pc_next = pcn_ctr;
        in_valid = 1'b1;
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("flush_interlock_clear", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("post_flush_accept", 32'(out_valid), 32'd1);
        chk("post_flush_reg_d", 32'(out_reg_d), 32'd4);
        step(2);

        // Asynchronous reset in the middle of a stalled stream
        out_ready = 1'b0;
        instruction = i_type(6'h08, 5'd1, 5'd2, 16'h0042);
        ctrl_in = C_ALU;
        pc_next = pcn_ctr;
        in_valid = 1'b1;
        step(4);
        #2;
        reset = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_pc_next", out_pc_next, 32'd0);
        chk("async_out_imm", out_imm, 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
`ifdef ID_ISSUE_PERF_EN
        chk("async_stall_cnt", stall_cnt, 32'd0);
        chk("async_bubble_cnt", bubble_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
